// File: rtl/ms_tagged_fifo_arb.sv
// Multi-flow tagged FIFO buffer with a round-robin drain into one tagged port.
// Optional MS_FIFO_COUNT_EN adds a port exposing per-flow occupancy.
module ms_tagged_fifo_arb #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int FLUX   = 2,
   localparam int TAG_W = $clog2(FLUX),
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [TAG_W+DATA_W-1:0] din,
   input  logic                    write,
   output logic [FLUX-1:0]         full,
   input  logic [FLUX-1:0]         flush,
   output logic [TAG_W+DATA_W-1:0] out_din,
   output logic                    out_write,
   input  logic [FLUX-1:0]         out_full,
   output logic                    err_ovf
`ifdef MS_FIFO_COUNT_EN
   ,
   output logic [FLUX*CNT_W-1:0]   count
`endif
);

   logic [DATA_W-1:0] mem_q [FLUX][DEPTH];

   logic [PTR_W-1:0] wr_ptr_q [FLUX];
   logic [PTR_W-1:0] wr_ptr_d [FLUX];
   logic [PTR_W-1:0] rd_ptr_q [FLUX];
   logic [PTR_W-1:0] rd_ptr_d [FLUX];
   logic [CNT_W-1:0] count_q  [FLUX];
   logic [CNT_W-1:0] count_d  [FLUX];

   logic [TAG_W-1:0]        rr_q, rr_d;
   logic                    out_write_q, out_write_d;
   logic [TAG_W+DATA_W-1:0] out_din_q, out_din_d;
   logic                    err_ovf_q, err_ovf_d;

   logic [TAG_W-1:0]  wr_tag;
   logic [DATA_W-1:0] wr_data;
   logic              tag_ok;
   logic              tag_full;
   logic [FLUX-1:0]   push;
   logic [FLUX-1:0]   pop;
   logic [FLUX-1:0]   eligible;
   logic              found;
   logic [TAG_W-1:0]  gnt;
   logic [DATA_W-1:0] head;

   assign wr_tag  = din[TAG_W+DATA_W-1:DATA_W];
   assign wr_data = din[DATA_W-1:0];

   // Full flags come only from registered occupancy, so a same-cycle pop never frees a slot.
   always_comb begin
      for (int f = 0; f < FLUX; f++) begin
         full[f] = (count_q[f] == CNT_W'(DEPTH));
      end
   end

   // Write-side decode: accept into the tagged FIFO or flag an overflow/bad tag.
   always_comb begin
      tag_ok   = 32'(wr_tag) < 32'(FLUX);
      tag_full = 1'b0;
      push     = '0;
      for (int f = 0; f < FLUX; f++) begin
         if (wr_tag == TAG_W'(f)) begin
            tag_full = full[f];
            push[f]  = write && !full[f] && !flush[f];
         end
      end
      if (!tag_ok) begin
         push = '0;
      end
      err_ovf_d = err_ovf_q | (write && (!tag_ok || tag_full));
   end

   // Round-robin grant starting at rr_q over flows with data and downstream room.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      gnt   = '0;
      for (int f = 0; f < FLUX; f++) begin
         eligible[f] = (count_q[f] != '0) && !out_full[f] && !flush[f];
      end
      for (int i = 0; i < FLUX; i++) begin
         idx = (int'(rr_q) + i) % FLUX;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            gnt   = TAG_W'(idx);
         end
      end
   end

   // Pop the granted FIFO and form the next registered output word.
   always_comb begin
      pop  = '0;
      head = '0;
      for (int f = 0; f < FLUX; f++) begin
         if (found && gnt == TAG_W'(f)) begin
            pop[f] = 1'b1;
            head   = mem_q[f][rd_ptr_q[f]];
         end
      end
      out_write_d = found;
      out_din_d   = out_din_q;
      rr_d        = rr_q;
      if (found) begin
         out_din_d = {gnt, head};
         if (gnt == TAG_W'(FLUX - 1)) begin
            rr_d = '0;
         end else begin
            rr_d = gnt + 1'b1;
         end
      end
   end

   // Per-flow pointer and occupancy update; flush wins over push and pop.
   always_comb begin
      for (int f = 0; f < FLUX; f++) begin
         wr_ptr_d[f] = wr_ptr_q[f];
         rd_ptr_d[f] = rd_ptr_q[f];
         count_d[f]  = count_q[f];
         if (flush[f]) begin
            wr_ptr_d[f] = '0;
            rd_ptr_d[f] = '0;
            count_d[f]  = '0;
         end else begin
            wr_ptr_d[f] = wr_ptr_q[f] + PTR_W'(push[f]);
            rd_ptr_d[f] = rd_ptr_q[f] + PTR_W'(pop[f]);
            count_d[f]  = count_q[f] + CNT_W'(push[f]) - CNT_W'(pop[f]);
         end
      end
   end

   // Control state registers; reset drops all buffered words at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int f = 0; f < FLUX; f++) begin
            wr_ptr_q[f] <= '0;
            rd_ptr_q[f] <= '0;
            count_q[f]  <= '0;
         end
         rr_q        <= '0;
         out_write_q <= 1'b0;
         out_din_q   <= '0;
         err_ovf_q   <= 1'b0;
      end else begin
         for (int f = 0; f < FLUX; f++) begin
            wr_ptr_q[f] <= wr_ptr_d[f];
            rd_ptr_q[f] <= rd_ptr_d[f];
            count_q[f]  <= count_d[f];
         end
         rr_q        <= rr_d;
         out_write_q <= out_write_d;
         out_din_q   <= out_din_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   // Payload storage; contents are don't-care whenever count is zero.
   always_ff @(posedge clk) begin
      for (int f = 0; f < FLUX; f++) begin
         if (push[f]) begin
            mem_q[f][wr_ptr_q[f]] <= wr_data;
         end
      end
   end

   assign out_write = out_write_q;
   assign out_din   = out_din_q;
   assign err_ovf   = err_ovf_q;

`ifdef MS_FIFO_COUNT_EN
   // Expose registered occupancy, flow f at slice f.
   always_comb begin
      for (int f = 0; f < FLUX; f++) begin
         count[f*CNT_W +: CNT_W] = count_q[f];
      end
   end
`endif

endmodule

// File: tb/tb_ms_tagged_fifo_arb.sv
// Directed bench for ms_tagged_fifo_arb: vector table plus corner sequences.
// A second instance with FLUX=4 covers skipping a blocked flow.
module tb_ms_tagged_fifo_arb;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] din = '0;
   logic       write = 1'b0;
   logic [1:0] flush = '0;
   logic [1:0] out_full = '0;
   logic [1:0] full;
   logic [8:0] out_din;
   logic       out_write;
   logic       err_ovf;

   logic [9:0] din4 = '0;
   logic       write4 = 1'b0;
   logic [3:0] flush4 = '0;
   logic [3:0] of4 = '0;
   logic [3:0] full4;
   logic [9:0] od4;
   logic       ow4;
   logic       err4;

`ifdef MS_FIFO_COUNT_EN
   logic [9:0]  cnt2;
   logic [19:0] cnt4;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ms_tagged_fifo_arb #(.DATA_W(8), .DEPTH(16), .FLUX(2)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .write     (write),
      .full      (full),
      .flush     (flush),
      .out_din   (out_din),
      .out_write (out_write),
      .out_full  (out_full),
      .err_ovf   (err_ovf)
`ifdef MS_FIFO_COUNT_EN
      ,
      .count     (cnt2)
`endif
   );

   ms_tagged_fifo_arb #(.DATA_W(8), .DEPTH(16), .FLUX(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .din       (din4),
      .write     (write4),
      .full      (full4),
      .flush     (flush4),
      .out_din   (od4),
      .out_write (ow4),
      .out_full  (of4),
      .err_ovf   (err4)
`ifdef MS_FIFO_COUNT_EN
      ,
      .count     (cnt4)
`endif
   );

   typedef struct {
      logic       wr;
      logic [8:0] din;
      logic [1:0] fl;
      logic [1:0] of;
      logic       ew;
      logic [8:0] ed;
      logic [1:0] ef;
      logic       ee;
   } vec_t;

   vec_t tv [12];
   logic [8:0] q [$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      write  = 1'b0;
      flush  = '0;
      out_full = '0;
      write4 = 1'b0;
      flush4 = '0;
      of4    = '0;
      rst    = 1'b1;
      #1;
      chk("rst_ow", 32'(out_write), 32'd0);
      chk("rst_od", 32'(out_din), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_err", 32'(err_ovf), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      tv[0]  = '{1'b1, 9'h011, 2'b00, 2'b00, 1'b0, 9'h000, 2'b00, 1'b0};
      tv[1]  = '{1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 9'h011, 2'b00, 1'b0};
      tv[2]  = '{1'b0, 9'h000, 2'b00, 2'b00, 1'b0, 9'h011, 2'b00, 1'b0};
      tv[3]  = '{1'b1, 9'h122, 2'b00, 2'b00, 1'b0, 9'h011, 2'b00, 1'b0};
      tv[4]  = '{1'b1, 9'h033, 2'b00, 2'b00, 1'b1, 9'h122, 2'b00, 1'b0};
      tv[5]  = '{1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 9'h033, 2'b00, 1'b0};
      tv[6]  = '{1'b1, 9'h044, 2'b00, 2'b01, 1'b0, 9'h033, 2'b00, 1'b0};
      tv[7]  = '{1'b0, 9'h000, 2'b00, 2'b01, 1'b0, 9'h033, 2'b00, 1'b0};
      tv[8]  = '{1'b0, 9'h000, 2'b00, 2'b00, 1'b1, 9'h044, 2'b00, 1'b0};
      tv[9]  = '{1'b1, 9'h155, 2'b00, 2'b00, 1'b0, 9'h044, 2'b00, 1'b0};
      tv[10] = '{1'b1, 9'h166, 2'b10, 2'b00, 1'b0, 9'h044, 2'b00, 1'b0};
      tv[11] = '{1'b0, 9'h000, 2'b00, 2'b00, 1'b0, 9'h044, 2'b00, 1'b0};

      do_reset();

      // table: basic latency, round robin, out_full hold, flush
      for (int i = 0; i < 12; i++) begin
         write    = tv[i].wr;
         din      = tv[i].din;
         flush    = tv[i].fl;
         out_full = tv[i].of;
         step();
         chk($sformatf("tv%0d_ow", i), 32'(out_write), 32'(tv[i].ew));
         chk($sformatf("tv%0d_od", i), 32'(out_din), 32'(tv[i].ed));
         chk($sformatf("tv%0d_full", i), 32'(full), 32'(tv[i].ef));
         chk($sformatf("tv%0d_err", i), 32'(err_ovf), 32'(tv[i].ee));
      end

      // T2: alternating writes, 32 words interleaved in order
      do_reset();
      q.delete();
      for (int s = 0; s < 35; s++) begin
         write = (s < 32);
         if (s % 2 == 0) din = {1'b0, 8'(s / 2)};
         else            din = {1'b1, 8'h80 + 8'(s / 2)};
         step();
         if (out_write) q.push_back(out_din);
      end
      write = 1'b0;
      chk("t2_nout", 32'(q.size()), 32'd32);
      for (int j = 0; j < 32 && j < q.size(); j++) begin
         if (j % 2 == 0) chk($sformatf("t2_w%0d", j), 32'(q[j]), 32'({1'b0, 8'(j / 2)}));
         else            chk($sformatf("t2_w%0d", j), 32'(q[j]), 32'({1'b1, 8'h80 + 8'(j / 2)}));
      end
      chk("t2_err", 32'(err_ovf), 32'd0);

      // T3: fill flow1, overflow, then drain exactly 16
      do_reset();
      out_full = 2'b11;
      for (int i = 0; i < 16; i++) begin
         write = 1'b1;
         din   = {1'b1, 8'(i)};
         step();
         if (i == 14) chk("t3_notfull15", 32'(full), 32'd0);
      end
      chk("t3_full", 32'(full), 32'b10);
      chk("t3_err0", 32'(err_ovf), 32'd0);
      din = 9'h1FF;
      step();
      chk("t3_err1", 32'(err_ovf), 32'd1);
      chk("t3_full17", 32'(full), 32'b10);
      q.delete();
      out_full = 2'b00;
      din = 9'h1EE;
      step();
      if (out_write) q.push_back(out_din);
      write = 1'b0;
      for (int s = 0; s < 20; s++) begin
         step();
         if (out_write) q.push_back(out_din);
      end
      chk("t3_nout", 32'(q.size()), 32'd16);
      for (int j = 0; j < 16 && j < q.size(); j++) begin
         chk($sformatf("t3_w%0d", j), 32'(q[j]), 32'({1'b1, 8'(j)}));
      end
      chk("t3_full_after", 32'(full), 32'd0);

      // T6: async reset mid-stream with both FIFOs half full and err set
      out_full = 2'b11;
      for (int i = 0; i < 16; i++) begin
         write = 1'b1;
         din   = {1'(i % 2), 8'h40 + 8'(i)};
         step();
      end
      write = 1'b0;
      out_full = 2'b00;
      step();
      chk("t6_pre_ow", 32'(out_write), 32'd1);
      chk("t6_pre_err", 32'(err_ovf), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_ow", 32'(out_write), 32'd0);
      chk("t6_od", 32'(out_din), 32'd0);
      chk("t6_full", 32'(full), 32'd0);
      chk("t6_err", 32'(err_ovf), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      for (int s = 0; s < 8; s++) begin
         step();
         if (out_write) q.push_back(out_din);
      end
      chk("t6_stale", 32'(q.size()), 32'd0);

      // T5: flush flow0 with a same-cycle write; flow1 unaffected
      do_reset();
      out_full = 2'b11;
      write = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = {1'b0, 8'h50 + 8'(i)};
         step();
      end
      din = 9'h161;
      step();
      flush = 2'b01;
      din = 9'h099;
      step();
`ifdef MS_FIFO_COUNT_EN
      chk("t5_cnt0", 32'(cnt2[4:0]), 32'd0);
      chk("t5_cnt1", 32'(cnt2[9:5]), 32'd1);
`endif
      chk("t5_err", 32'(err_ovf), 32'd0);
      flush = 2'b00;
      write = 1'b0;
      out_full = 2'b00;
      q.delete();
      for (int s = 0; s < 8; s++) begin
         step();
         if (out_write) q.push_back(out_din);
      end
      chk("t5_nout", 32'(q.size()), 32'd1);
      if (q.size() > 0) chk("t5_w", 32'(q[0]), 32'h161);

      // T4: FLUX=4, flow2 blocked, grants alternate 0,3
      do_reset();
      of4 = 4'b1111;
      write4 = 1'b1;
      din4 = {2'd0, 8'hA0}; step();
      din4 = {2'd0, 8'hA1}; step();
      din4 = {2'd2, 8'hC0}; step();
      din4 = {2'd2, 8'hC1}; step();
      din4 = {2'd3, 8'hD0}; step();
      din4 = {2'd3, 8'hD1}; step();
      write4 = 1'b0;
      chk("t4_ow_blk", 32'(ow4), 32'd0);
      of4 = 4'b0100;
      step(); chk("t4_g0", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd0, 8'hA0}));
      step(); chk("t4_g1", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd3, 8'hD0}));
      step(); chk("t4_g2", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd0, 8'hA1}));
      step(); chk("t4_g3", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd3, 8'hD1}));
      step(); chk("t4_idle", 32'(ow4), 32'd0);
      of4 = 4'b0000;
      step(); chk("t4_g4", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd2, 8'hC0}));
      step(); chk("t4_g5", 32'(ow4 ? od4 : 10'h3FF), 32'({2'd2, 8'hC1}));
      step(); chk("t4_end", 32'(ow4), 32'd0);
      chk("t4_err", 32'(err4), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
